positadd_issuer: RTL

// - Initiator-side front end for the positadd responder (start/done handshake, in1/in2 -> result/inf/zero).
// - Accepts operand pairs on a valid/ready stream and drives one add at a time into positadd.
// - Returns result plus inf/zero flags on a valid/ready output stream.
// - Sits between the pair-HMM datapath and each positadd instance.

---
 rtl/posit_pkg.sv | 24 ++
 rtl/positadd_issuer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared posit constants, issuer FSM encoding and result record.
package posit_pkg;

    localparam int N  = 32;
    localparam int ES = 2;

    // Not-a-Real: sign bit set, everything else clear.
    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } issuer_state_t;

    typedef struct packed {
        logic [N-1:0] result;
        logic         inf;
        logic         zero;
        logic         err;
    } posit_res_t;

endpackage

// File: rtl/positadd_issuer.sv
// positadd_issuer: valid/ready front end that drives one add at a time into
// a positadd responder (start/done) and returns the sum on an output stream.
// Optional feature macro: POSITADD_ISSUER_TIMEOUT_EN (abort a WAIT that
// exceeds TIMEOUT_CYC cycles and return NaR with out_err set).
module positadd_issuer #(
    parameter int N           = 32,
    parameter int ES          = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic         add_start,
    output logic [N-1:0] add_in1,
    output logic [N-1:0] add_in2,
    input  logic         add_done,
    input  logic [N-1:0] add_result,
    input  logic         add_inf,
    input  logic         add_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic         out_inf,
    output logic         out_zero,
    output logic         out_err,
    output logic [31:0]  op_count
);
    import posit_pkg::*;

    localparam logic [N-1:0] NAR_W = {1'b1, {(N-1){1'b0}}};

    issuer_state_t state, state_nxt;
    logic          take_in;
    logic          timeout;

    if (N < 2 || ES < 0 || ES > N - 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("positadd_issuer: invalid parameter set");
    end

    // Accept a pair when idle, or when the current result leaves this cycle.
    assign in_ready  = rst_n && ((state == IDLE) || (state == OUT && out_ready));
    assign take_in   = in_ready && in_valid;
    // Gated by rst_n so the pulse dies the instant reset is asserted.
    assign add_start = rst_n && (state == ISSUE);
    assign out_valid = (state == OUT);

`ifdef POSITADD_ISSUER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    logic          err_q;

    // Count cycles spent in WAIT; cleared while the start pulse is out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (state == ISSUE)
            wait_cnt <= '0;
        else if (state == WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // A done in the final WAIT cycle still wins over the abort.
    assign timeout = (state == WAIT) && !add_done && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    // Abort marker travels with the captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (state == WAIT && (add_done || timeout))
            err_q <= timeout;
    end

    assign out_err = err_q;
`else
    assign timeout = 1'b0;
    assign out_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; done is only honoured in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_in) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (add_done || timeout) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = in_valid ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand registers feed the responder and stay put until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_in1 <= '0;
            add_in2 <= '0;
        end else if (take_in) begin
            add_in1 <= in_a;
            add_in2 <= in_b;
        end
    end

    // Capture the responder's answer, or NaR/inf on an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_inf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (state == WAIT && add_done) begin
            out_result <= add_result;
            out_inf    <= add_inf;
            out_zero   <= add_zero;
        end else if (timeout) begin
            out_result <= NAR_W;
            out_inf    <= 1'b1;
            out_zero   <= 1'b0;
        end
    end

    // Completed-operation counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (out_valid && out_ready)
            op_count <= op_count + 32'd1;
    end

endmodule
